apb_requester: RTL and testbench
================================

Name: apb_requester

Overview:
Parametrised APB5 requester that turns a simple valid/ready command/response pair into APB SETUP/ACCESS transfers across NUM_SLAVES completers. It decodes the completer from address bits and drives a one-hot PSEL vector. It muxes the per-completer PREADY, PRDATA and PSLVERR back, and aborts stalled transfers with a programmable timeout. It sits between an internal bus client (CPU bridge, DMA, test sequencer) and the APB fabric, and it drives the signal set carried by the team's APB master interface.

Parameters:
ADDR_WIDTH, 32, PADDR and cmd_addr width.
DATA_WIDTH, 32, data width; legal values 8, 16, 32. PSTRB width is DATA_WIDTH/8.
NUM_SLAVES, 4, number of completers; 1..16.
SEL_LSB, 12, lowest address bit of the completer index field. The field is SEL_W=$clog2(NUM_SLAVES) bits wide; when NUM_SLAVES=1, SEL_W=0.
TIMEOUT_CYCLES, 16, maximum ACCESS cycles before abort; 0 disables the timeout.

Ports:
PCLK  in  1  clock
PRESET  in  1  reset; synchronous, active-low
cmd_valid  in  1  command request
cmd_ready  out  1  command accepted when high together with cmd_valid
cmd_write  in  1  1=write, 0=read
cmd_addr  in  ADDR_WIDTH  byte address
cmd_wdata  in  DATA_WIDTH  write data
cmd_strb  in  DATA_WIDTH/8  write byte strobes
cmd_prot  in  3  PPROT value
cmd_nse  in  1  PNSE value
rsp_valid  out  1  response available
rsp_ready  in  1  response consumed
rsp_rdata  out  DATA_WIDTH  read data; 0 for writes and for errors
rsp_err  out  1  PSLVERR, decode error or timeout
rsp_timeout  out  1  set only when the transfer timed out
PADDR  out  ADDR_WIDTH
PPROT  out  3
PNSE  out  1
PSEL  out  NUM_SLAVES  one-hot completer select
PENABLE  out  1
PWRITE  out  1
PWDATA  out  DATA_WIDTH
PSTRB  out  DATA_WIDTH/8
PWAKEUP  out  1
PREADY  in  NUM_SLAVES  per-completer ready
PRDATA  in  NUM_SLAVES*DATA_WIDTH  per-completer read data; completer i occupies bits [i*DATA_WIDTH +: DATA_WIDTH]
PSLVERR  in  NUM_SLAVES  per-completer error

Behaviour:
- Reset (PRESET=0 at a PCLK edge) applies from any state, including mid-transfer:
  - every output is driven to 0, including cmd_ready, PSEL and PWAKEUP;
  - the FSM returns to IDLE and the timeout counter clears;
  - an in-flight transfer is dropped and no response is produced.
- FSM states are IDLE, SETUP, ACCESS and RESP. All APB outputs are registered.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid&&cmd_ready, register the command and compute idx=cmd_addr[SEL_LSB +: SEL_W].
  - If idx<NUM_SLAVES, go to SETUP. Otherwise it is a decode error: go to RESP with rsp_err=1, rsp_timeout=0, rsp_rdata=0, and no PSEL is ever asserted.
- SETUP (exactly 1 cycle):
  - PSEL[idx]=1, PENABLE=0.
  - PADDR, PWRITE, PPROT, PNSE and PWDATA carry the command values.
  - PSTRB=cmd_strb for writes; PSTRB=0 for reads.
  - Next state is ACCESS.
- ACCESS:
  - PENABLE=1. All address, control and data outputs are held stable.
  - Timeout counter starts at 0 on the first ACCESS cycle and increments each cycle PREADY[idx]=0.
  - If PREADY[idx]=1: capture rsp_rdata=PRDATA slice idx (reads only, and only if PSLVERR[idx]=0; otherwise 0) and rsp_err=PSLVERR[idx]. Deassert PSEL and PENABLE on the next edge and go to RESP.
  - Else, if TIMEOUT_CYCLES!=0 and the counter equals TIMEOUT_CYCLES-1: abort. Deassert PSEL and PENABLE; rsp_err=1, rsp_timeout=1, rsp_rdata=0; go to RESP.
  - If PREADY arrives in the same cycle the timeout would fire, PREADY wins and the transfer completes normally.
- RESP:
  - rsp_valid=1; response fields are held stable until rsp_ready.
  - On rsp_valid&&rsp_ready, go to IDLE.
  - cmd_ready=0 throughout RESP. Only one transfer is outstanding at a time.
- Latency: command accepted at edge N gives SETUP in cycle N+1 and ACCESS in N+2. With zero wait states, rsp_valid is high from N+3. The minimum command-to-command spacing is 4 cycles, with rsp_ready tied high.
- PWAKEUP goes high the cycle after cmd_valid is seen in IDLE. It stays high until the transfer's rsp handshake, then drops unless cmd_valid is high again.
- PREADY, PRDATA and PSLVERR of unselected completers are ignored.
- PSEL has at most one bit set in every cycle.

Decomposition:
- apb_pkg holds:
  - the state enum (IDLE, SETUP, ACCESS, RESP);
  - PPROT bit constants (PROT_PRIV=0, PROT_NONSEC=1, PROT_INSTR=2);
  - a packed struct for the registered command (write, addr, wdata, strb, prot, nse, idx).
- One sub-module, apb_slave_decoder:
  - input: address;
  - outputs: idx, an in-range flag and the one-hot select;
  - it also muxes PREADY, PRDATA and PSLVERR by idx.
- The FSM and timeout logic live in apb_requester.

Test Plan:
- Write of 0xDEADBEEF, strb 4'hF, to addr 0x0000_1004 (idx 1), completer 1 PREADY=1 immediately -> PSEL=4'b0010 for 2 cycles, PENABLE only in the 2nd, PSTRB=4'hF, rsp_valid at N+3 with rsp_err=0.
- Read of 0x2000 (idx 2), PREADY held low 3 ACCESS cycles, PRDATA slice 2=0x1234_5678 -> PADDR, PWRITE=0 and PSTRB=0 stable throughout, rsp_rdata=0x1234_5678, rsp_valid at N+6.
- Read with PSLVERR[0]=1 at PREADY -> rsp_err=1, rsp_timeout=0, rsp_rdata=0.
- TIMEOUT_CYCLES=16, completer 3 never ready -> exactly 16 ACCESS cycles, then PSEL=0, rsp_err=1, rsp_timeout=1; PREADY on the 16th ACCESS cycle instead completes normally.
- NUM_SLAVES=3, addr 0x3000 (idx 3) -> PSEL stays 0, rsp_valid with rsp_err=1 at N+1; next command accepted after the handshake.
- PRESET=0 during ACCESS -> all outputs 0 the next cycle, no rsp_valid; after release, cmd_ready=1 and a new write completes normally.

Source files
------------

// File: rtl/apb_pkg.sv
// rtl/apb_pkg.sv - shared types and constants for the APB requester
package apb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_t;

    localparam int PROT_PRIV   = 0;
    localparam int PROT_NONSEC = 1;
    localparam int PROT_INSTR  = 2;

    // Field widths sized for the largest supported configuration
    localparam int MAX_ADDR_W = 64;
    localparam int MAX_DATA_W = 32;
    localparam int MAX_STRB_W = MAX_DATA_W / 8;
    localparam int MAX_IDX_W  = 4;

    typedef struct packed {
        logic                  write;
        logic [MAX_ADDR_W-1:0] addr;
        logic [MAX_DATA_W-1:0] wdata;
        logic [MAX_STRB_W-1:0] strb;
        logic [2:0]            prot;
        logic                  nse;
        logic [MAX_IDX_W-1:0]  idx;
    } cmd_t;

endpackage

// File: rtl/apb_requester_if.sv
// rtl/apb_requester_if.sv - APB5 bus signal bundle with requester/completer views
interface apb_requester_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_SLAVES = 4
);
    logic [ADDR_WIDTH-1:0]            PADDR;
    logic [2:0]                       PPROT;
    logic                             PNSE;
    logic [NUM_SLAVES-1:0]            PSEL;
    logic                             PENABLE;
    logic                             PWRITE;
    logic [DATA_WIDTH-1:0]            PWDATA;
    logic [DATA_WIDTH/8-1:0]          PSTRB;
    logic                             PWAKEUP;
    logic [NUM_SLAVES-1:0]            PREADY;
    logic [NUM_SLAVES*DATA_WIDTH-1:0] PRDATA;
    logic [NUM_SLAVES-1:0]            PSLVERR;

    modport master (
        output PADDR, PPROT, PNSE, PSEL, PENABLE, PWRITE, PWDATA, PSTRB, PWAKEUP,
        input  PREADY, PRDATA, PSLVERR
    );

    modport slave (
        input  PADDR, PPROT, PNSE, PSEL, PENABLE, PWRITE, PWDATA, PSTRB, PWAKEUP,
        output PREADY, PRDATA, PSLVERR
    );
endinterface

// File: rtl/apb_slave_decoder.sv
// rtl/apb_slave_decoder.sv - completer index decode and per-completer response mux
module apb_slave_decoder
    import apb_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_SLAVES = 4,
    parameter int SEL_LSB    = 12
) (
    input  logic [ADDR_WIDTH-1:0]            addr,
    input  logic [MAX_IDX_W-1:0]             sel_idx,
    output logic [MAX_IDX_W-1:0]             idx,
    output logic                             in_range,
    output logic [NUM_SLAVES-1:0]            sel,
    input  logic [NUM_SLAVES-1:0]            pready,
    input  logic [NUM_SLAVES*DATA_WIDTH-1:0] prdata,
    input  logic [NUM_SLAVES-1:0]            pslverr,
    output logic                             pready_sel,
    output logic [DATA_WIDTH-1:0]            prdata_sel,
    output logic                             pslverr_sel
);
    localparam int SEL_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 0;

    logic unused_addr;
    assign unused_addr = ^addr;

    generate
        if (SEL_W > 0) begin : g_field
            assign idx = MAX_IDX_W'(addr[SEL_LSB +: SEL_W]);
        end else begin : g_single
            assign idx = '0;
        end
    endgenerate

    // Extra bit so NUM_SLAVES=16 does not wrap to zero
    assign in_range = ({1'b0, idx} < (MAX_IDX_W + 1)'(NUM_SLAVES));

    // sel decodes the incoming address; the response mux follows the latched index
    always_comb begin
        sel         = '0;
        pready_sel  = 1'b0;
        prdata_sel  = '0;
        pslverr_sel = 1'b0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (idx == MAX_IDX_W'(i)) sel[i] = 1'b1;
            if (sel_idx == MAX_IDX_W'(i)) begin
                pready_sel  = pready[i];
                prdata_sel  = prdata[i*DATA_WIDTH +: DATA_WIDTH];
                pslverr_sel = pslverr[i];
            end
        end
    end
endmodule

// File: rtl/apb_requester.sv
// rtl/apb_requester.sv - valid/ready command to APB5 SETUP/ACCESS transfers with timeout
module apb_requester
    import apb_pkg::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int NUM_SLAVES     = 4,
    parameter int SEL_LSB        = 12,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                    PCLK,
    input  logic                    PRESET,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic                    cmd_write,
    input  logic [ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [DATA_WIDTH-1:0]   cmd_wdata,
    input  logic [DATA_WIDTH/8-1:0] cmd_strb,
    input  logic [2:0]              cmd_prot,
    input  logic                    cmd_nse,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [DATA_WIDTH-1:0]   rsp_rdata,
    output logic                    rsp_err,
    output logic                    rsp_timeout,
    apb_requester_if.master         apb
);
    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] TO_LAST = (TIMEOUT_CYCLES > 0) ? CW'(TIMEOUT_CYCLES - 1) : '0;

    state_t                  state_q, state_d;
    cmd_t                    cq;
    logic [NUM_SLAVES-1:0]   psel_q;
    logic                    penable_q, pwakeup_q, wake_d;
    logic [CW-1:0]           cnt_q;
    logic [DATA_WIDTH-1:0]   rsp_rdata_q;
    logic                    rsp_err_q, rsp_timeout_q;
    logic                    accept, done, abort;

    logic [MAX_IDX_W-1:0]    dec_idx;
    logic                    dec_in_range;
    logic [NUM_SLAVES-1:0]   dec_sel;
    logic                    pready_sel, pslverr_sel;
    logic [DATA_WIDTH-1:0]   prdata_sel;

    apb_slave_decoder #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .NUM_SLAVES (NUM_SLAVES),
        .SEL_LSB    (SEL_LSB)
    ) u_dec (
        .addr        (cmd_addr),
        .sel_idx     (cq.idx),
        .idx         (dec_idx),
        .in_range    (dec_in_range),
        .sel         (dec_sel),
        .pready      (apb.PREADY),
        .prdata      (apb.PRDATA),
        .pslverr     (apb.PSLVERR),
        .pready_sel  (pready_sel),
        .prdata_sel  (prdata_sel),
        .pslverr_sel (pslverr_sel)
    );

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        done    = 1'b0;
        abort   = 1'b0;
        wake_d  = pwakeup_q;
        unique case (state_q)
            IDLE: begin
                wake_d = cmd_valid;
                if (cmd_valid) begin
                    accept  = 1'b1;
                    state_d = dec_in_range ? SETUP : RESP;
                end
            end
            SETUP: state_d = ACCESS;
            ACCESS: begin
                // A late PREADY beats the timeout on the same cycle
                if (pready_sel) begin
                    done    = 1'b1;
                    state_d = RESP;
                end else if (TIMEOUT_CYCLES != 0 && cnt_q == TO_LAST) begin
                    abort   = 1'b1;
                    state_d = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                    wake_d  = cmd_valid;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge PCLK) begin
        if (!PRESET) begin
            state_q       <= IDLE;
            cq            <= '0;
            psel_q        <= '0;
            penable_q     <= 1'b0;
            pwakeup_q     <= 1'b0;
            cnt_q         <= '0;
            rsp_rdata_q   <= '0;
            rsp_err_q     <= 1'b0;
            rsp_timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pwakeup_q <= wake_d;
            if (accept) begin
                cq.write      <= cmd_write;
                cq.addr       <= MAX_ADDR_W'(cmd_addr);
                cq.wdata      <= MAX_DATA_W'(cmd_wdata);
                cq.strb       <= cmd_write ? MAX_STRB_W'(cmd_strb) : '0;
                cq.prot       <= cmd_prot;
                cq.nse        <= cmd_nse;
                cq.idx        <= dec_idx;
                psel_q        <= dec_sel;
                rsp_rdata_q   <= '0;
                rsp_err_q     <= !dec_in_range;
                rsp_timeout_q <= 1'b0;
            end
            if (state_q == SETUP) begin
                penable_q <= 1'b1;
                cnt_q     <= '0;
            end
            if (state_q == ACCESS && !pready_sel && !abort) cnt_q <= cnt_q + CW'(1);
            if (done) begin
                psel_q      <= '0;
                penable_q   <= 1'b0;
                rsp_err_q   <= pslverr_sel;
                rsp_rdata_q <= (!cq.write && !pslverr_sel) ? prdata_sel : '0;
            end
            if (abort) begin
                psel_q        <= '0;
                penable_q     <= 1'b0;
                rsp_err_q     <= 1'b1;
                rsp_timeout_q <= 1'b1;
                rsp_rdata_q   <= '0;
            end
        end
    end

    logic unused_cq;
    assign unused_cq = ^cq;

    assign cmd_ready   = (state_q == IDLE) && PRESET;
    assign rsp_valid   = (state_q == RESP);
    assign rsp_rdata   = rsp_rdata_q;
    assign rsp_err     = rsp_err_q;
    assign rsp_timeout = rsp_timeout_q;

    assign apb.PADDR   = cq.addr[ADDR_WIDTH-1:0];
    assign apb.PPROT   = cq.prot;
    assign apb.PNSE    = cq.nse;
    assign apb.PSEL    = psel_q;
    assign apb.PENABLE = penable_q;
    assign apb.PWRITE  = cq.write;
    assign apb.PWDATA  = cq.wdata[DATA_WIDTH-1:0];
    assign apb.PSTRB   = cq.strb[DATA_WIDTH/8-1:0];
    assign apb.PWAKEUP = pwakeup_q;
endmodule

// File: tb/tb_apb_requester.sv
// tb/tb_apb_requester.sv - directed self-checking bench for apb_requester
module tb_apb_requester;
    import apb_pkg::*;

    logic        pclk = 1'b0;
    logic        presetn;
    logic        cmd_valid, cmd_valid3, cmd_write, cmd_nse;
    logic        cmd_ready, cmd_ready3;
    logic [31:0] cmd_addr, cmd_wdata;
    logic [3:0]  cmd_strb;
    logic [2:0]  cmd_prot;
    logic        rsp_ready, rsp_ready3;
    logic        rsp_valid, rsp_err, rsp_timeout;
    logic        rsp_valid3, rsp_err3, rsp_timeout3;
    logic [31:0] rsp_rdata, rsp_rdata3;
    int          ncmp = 0;
    int          nfail = 0;

    apb_requester_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .NUM_SLAVES(4)) b4 ();
    apb_requester_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .NUM_SLAVES(3)) b3 ();

    always #5 pclk = ~pclk;

    apb_requester #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .NUM_SLAVES(4), .SEL_LSB(12), .TIMEOUT_CYCLES(16)) dut4 (
        .PCLK(pclk), .PRESET(presetn), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb),
        .cmd_prot(cmd_prot), .cmd_nse(cmd_nse), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .rsp_timeout(rsp_timeout), .apb(b4)
    );

    apb_requester #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .NUM_SLAVES(3), .SEL_LSB(12), .TIMEOUT_CYCLES(16)) dut3 (
        .PCLK(pclk), .PRESET(presetn), .cmd_valid(cmd_valid3), .cmd_ready(cmd_ready3),
        .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb),
        .cmd_prot(cmd_prot), .cmd_nse(cmd_nse), .rsp_valid(rsp_valid3), .rsp_ready(rsp_ready3),
        .rsp_rdata(rsp_rdata3), .rsp_err(rsp_err3), .rsp_timeout(rsp_timeout3), .apb(b3)
    );

    task automatic step();
        @(posedge pclk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic wr, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        cmd_write = wr;
        cmd_addr  = a;
        cmd_wdata = d;
        cmd_strb  = s;
    endtask

    initial begin
        presetn = 1'b0;
        cmd_valid = 1'b0; cmd_valid3 = 1'b0; rsp_ready = 1'b0; rsp_ready3 = 1'b0;
        issue(1'b0, 32'h0, 32'h0, 4'h0);
        cmd_prot = 3'b000; cmd_nse = 1'b0;
        b4.PREADY = '0; b4.PRDATA = '0; b4.PSLVERR = '0;
        b3.PREADY = '0; b3.PRDATA = '0; b3.PSLVERR = '0;
        step(); step();

        chk("rst_cmd_ready", cmd_ready, 0);
        chk("rst_psel", b4.PSEL, 0);
        chk("rst_pwakeup", b4.PWAKEUP, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        presetn = 1'b1;
        step();
        chk("idle_cmd_ready", cmd_ready, 1);

        // Zero-wait write to completer 1
        b4.PREADY = 4'b0010;
        issue(1'b1, 32'h0000_1004, 32'hDEAD_BEEF, 4'hF);
        cmd_valid = 1'b1;
        step();
        cmd_valid = 1'b0;
        chk("wr_setup_psel", b4.PSEL, 4'b0010);
        chk("wr_setup_penable", b4.PENABLE, 0);
        chk("wr_setup_paddr", b4.PADDR, 32'h0000_1004);
        chk("wr_setup_pwdata", b4.PWDATA, 32'hDEAD_BEEF);
        chk("wr_setup_pstrb", b4.PSTRB, 4'hF);
        chk("wr_setup_pwrite", b4.PWRITE, 1);
        chk("wr_setup_cmd_ready", cmd_ready, 0);
        chk("wr_pwakeup", b4.PWAKEUP, 1);
        step();
        chk("wr_access_psel", b4.PSEL, 4'b0010);
        chk("wr_access_penable", b4.PENABLE, 1);
        chk("wr_access_rsp_valid", rsp_valid, 0);
        step();
        chk("wr_rsp_valid", rsp_valid, 1);
        chk("wr_rsp_err", rsp_err, 0);
        chk("wr_rsp_rdata", rsp_rdata, 0);
        chk("wr_rsp_psel", b4.PSEL, 0);
        chk("wr_rsp_pwakeup", b4.PWAKEUP, 1);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        chk("wr_done_rsp_valid", rsp_valid, 0);
        chk("wr_done_cmd_ready", cmd_ready, 1);
        chk("wr_done_pwakeup", b4.PWAKEUP, 0);

        // Read from completer 2 with three wait states; completer 1 noise must be ignored
        b4.PREADY = 4'b0010; b4.PSLVERR = 4'b0010;
        b4.PRDATA = {32'h0, 32'h1234_5678, 32'hAAAA_AAAA, 32'h0};
        cmd_prot = (3'b001 << PROT_PRIV) | (3'b001 << PROT_INSTR);
        cmd_nse = 1'b1;
        issue(1'b0, 32'h0000_2000, 32'h1111_2222, 4'hF);
        cmd_valid = 1'b1;
        step();
        cmd_valid = 1'b0;
        chk("rd_setup_psel", b4.PSEL, 4'b0100);
        chk("rd_setup_pstrb", b4.PSTRB, 0);
        chk("rd_setup_pprot", b4.PPROT, 3'b101);
        chk("rd_setup_pnse", b4.PNSE, 1);
        for (int k = 0; k < 3; k++) begin
            step();
            chk("rd_wait_penable", b4.PENABLE, 1);
            chk("rd_wait_paddr", b4.PADDR, 32'h0000_2000);
            chk("rd_wait_pwrite_pstrb", {b4.PWRITE, b4.PSTRB}, 5'b0);
            chk("rd_wait_rsp_valid", rsp_valid, 0);
        end
        step();
        chk("rd_4th_access_rsp_valid", rsp_valid, 0);
        b4.PREADY = 4'b0110;
        step();
        chk("rd_rsp_valid", rsp_valid, 1);
        chk("rd_rsp_rdata", rsp_rdata, 32'h1234_5678);
        chk("rd_rsp_err", rsp_err, 0);
        b4.PRDATA = '0;
        step();
        chk("rd_rsp_held", {rsp_valid, rsp_rdata}, {1'b1, 32'h1234_5678});
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        chk("rd_done_cmd_ready", cmd_ready, 1);

        // Read with slave error on completer 0
        b4.PREADY = 4'b0001; b4.PSLVERR = 4'b0001;
        b4.PRDATA = {96'h0, 32'hCAFE_F00D};
        issue(1'b0, 32'h0000_0010, 32'h0, 4'h0);
        cmd_valid = 1'b1;
        step();
        cmd_valid = 1'b0;
        step(); step();
        chk("err_rsp_valid", rsp_valid, 1);
        chk("err_rsp_err", rsp_err, 1);
        chk("err_rsp_timeout", rsp_timeout, 0);
        chk("err_rsp_rdata", rsp_rdata, 0);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;

        // Completer 3 never ready: abort after exactly 16 ACCESS cycles
        b4.PREADY = '0; b4.PSLVERR = '0; b4.PRDATA = '0;
        issue(1'b0, 32'h0000_3000, 32'h0, 4'h0);
        cmd_valid = 1'b1;
        step();
        cmd_valid = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            step();
            chk("to_access", {b4.PSEL, b4.PENABLE, rsp_valid}, {4'b1000, 1'b1, 1'b0});
        end
        step();
        chk("to_psel", b4.PSEL, 0);
        chk("to_penable", b4.PENABLE, 0);
        chk("to_rsp", {rsp_valid, rsp_err, rsp_timeout}, 3'b111);
        chk("to_rdata", rsp_rdata, 0);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;

        // PREADY on the 16th ACCESS cycle completes normally
        issue(1'b0, 32'h0000_3000, 32'h0, 4'h0);
        cmd_valid = 1'b1;
        step();
        cmd_valid = 1'b0;
        for (int k = 1; k <= 15; k++) step();
        step();
        chk("late_16th_access", {b4.PENABLE, rsp_valid}, 2'b10);
        b4.PREADY = 4'b1000;
        b4.PRDATA = {32'h55AA_55AA, 96'h0};
        step();
        chk("late_rsp", {rsp_valid, rsp_err, rsp_timeout}, 3'b100);
        chk("late_rdata", rsp_rdata, 32'h55AA_55AA);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        b4.PREADY = '0; b4.PRDATA = '0;

        // Decode error on the 3-completer instance
        issue(1'b0, 32'h0000_3000, 32'h0, 4'h0);
        cmd_valid3 = 1'b1;
        step();
        cmd_valid3 = 1'b0;
        chk("dec_psel", b3.PSEL, 0);
        chk("dec_rsp", {rsp_valid3, rsp_err3, rsp_timeout3}, 3'b110);
        chk("dec_rdata", rsp_rdata3, 0);
        chk("dec_cmd_ready", cmd_ready3, 0);
        rsp_ready3 = 1'b1;
        step();
        rsp_ready3 = 1'b0;
        chk("dec_after_cmd_ready", cmd_ready3, 1);
        b3.PREADY = 3'b010;
        b3.PRDATA = {32'h0, 32'h0BAD_CAFE, 32'h0};
        issue(1'b0, 32'h0000_1000, 32'h0, 4'h0);
        cmd_valid3 = 1'b1;
        step();
        cmd_valid3 = 1'b0;
        chk("dec_next_psel", b3.PSEL, 3'b010);
        step(); step();
        chk("dec_next_rsp", {rsp_valid3, rsp_err3, rsp_rdata3}, {2'b10, 32'h0BAD_CAFE});
        rsp_ready3 = 1'b1;
        step();
        rsp_ready3 = 1'b0;

        // Reset mid-ACCESS drops the transfer
        issue(1'b1, 32'h0000_1008, 32'h7777_8888, 4'hF);
        cmd_valid = 1'b1;
        step();
        cmd_valid = 1'b0;
        step();
        chk("rst_mid_in_access", b4.PENABLE, 1);
        presetn = 1'b0;
        step();
        chk("rst_mid_apb", {b4.PSEL, b4.PENABLE, b4.PWRITE, b4.PSTRB, b4.PWAKEUP}, 11'b0);
        chk("rst_mid_paddr_pwdata", {b4.PADDR, b4.PWDATA}, 64'h0);
        chk("rst_mid_rsp", {rsp_valid, rsp_err, rsp_timeout, cmd_ready}, 4'b0);
        b4.PREADY = 4'b0010;
        presetn = 1'b1;
        step();
        chk("rst_rel_rsp_valid", rsp_valid, 0);
        chk("rst_rel_cmd_ready", cmd_ready, 1);
        issue(1'b1, 32'h0000_1004, 32'h0BAD_F00D, 4'b0011);
        cmd_valid = 1'b1;
        step();
        cmd_valid = 1'b0;
        chk("rst_new_pstrb", {b4.PSEL, b4.PSTRB}, {4'b0010, 4'b0011});
        step(); step();
        chk("rst_new_rsp", {rsp_valid, rsp_err, rsp_timeout}, 3'b100);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        chk("rst_new_idle", cmd_ready, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end
endmodule
